// File: rtl/_rr_arbiter_if.sv
// Requester/sink bundle for the round-robin arbiter: per-requester req/lock/data
// in, one-hot grant back, and the registered output channel with its handshake.
interface _rr_arbiter_if #(
    parameter int n = 4,
    parameter int w = 16
);
    localparam int s = (n > 1) ? $clog2(n) : 1;

    logic [n-1:0]        req;
    logic [n-1:0]        lock;
    logic [n-1:0][w-1:0] in;
    logic [n-1:0]        gnt;
    logic                out_valid;
    logic                out_ready;
    logic [w-1:0]        out;
    logic [s-1:0]        out_sel;

    // Sources and the sink live on the master side; the arbiter is the slave.
    modport master (
        output req, lock, in, out_ready,
        input  gnt, out_valid, out, out_sel
    );

    modport slave (
        input  req, lock, in, out_ready,
        output gnt, out_valid, out, out_sel
    );
endinterface

// File: rtl/_rr_arbiter.sv
// Round-robin arbiter with optional burst locking, feeding one registered
// output word (valid/ready) from the granted requester.
module _rr_arbiter #(
    parameter int n         = 4,
    parameter int w         = 16,
    parameter int max_burst = 4
) (
    input logic            clk,
    input logic            rst,
    _rr_arbiter_if.slave   bus
);
    localparam int s  = (n > 1) ? $clog2(n) : 1;
    localparam int bw = $clog2(max_burst) + 1;
    localparam logic [s-1:0] PTR_RST = s'(n - 1);

    logic [s-1:0]  ptr_q, ptr_d;
    logic [bw-1:0] bcnt_q, bcnt_d;
    logic [w-1:0]  out_q, out_d;
    logic [s-1:0]  sel_q, sel_d;
    logic          vld_q, vld_d;

    logic          can_load;
    logic          hit;
    logic          take;
    logic [s-1:0]  gidx;
    logic [bw-1:0] bcnt_nxt;
    logic [n-1:0]  gnt;
    int            j;

    always_comb begin
        can_load = !vld_q || bus.out_ready;
        hit      = 1'b0;
        gidx     = ptr_q;
        bcnt_nxt = '0;
        j        = 0;

        // A locked holder keeps the channel until its burst allowance runs out.
        if (bus.req[ptr_q] && bus.lock[ptr_q] && (int'(bcnt_q) < max_burst - 1)) begin
            hit      = 1'b1;
            bcnt_nxt = bcnt_q + 1'b1;
        end else begin
            for (int i = 1; i <= n; i++) begin
                j = (int'(ptr_q) + i) % n;
                if (!hit && bus.req[j]) begin
                    hit  = 1'b1;
                    gidx = j[s-1:0];
                end
            end
        end

        take = hit && can_load && !rst;
        gnt  = '0;
        if (take) gnt[gidx] = 1'b1;

        ptr_d  = ptr_q;
        bcnt_d = bcnt_q;
        out_d  = out_q;
        sel_d  = sel_q;
        vld_d  = vld_q;
        if (take) begin
            out_d  = bus.in[gidx];
            sel_d  = gidx;
            vld_d  = 1'b1;
            ptr_d  = gidx;
            bcnt_d = bcnt_nxt;
        end else if (bus.out_ready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= PTR_RST;
            bcnt_q <= '0;
            out_q  <= '0;
            sel_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            bcnt_q <= bcnt_d;
            out_q  <= out_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.out       = out_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb__rr_arbiter.sv
// Bench for _rr_arbiter (n=4, w=16, max_burst=3): table of grant vectors plus
// hand sequences for drain, stall, and reset while a word is held.
module tb__rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    _rr_arbiter_if #(.n(4), .w(16)) bus ();
    _rr_arbiter #(.n(4), .w(16), .max_burst(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  sel;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l,
                                input logic rdy, input logic [3:0] g);
        vec_t v;
        v.req = r; v.lock = l; v.rdy = rdy; v.gnt = g;
        return v;
    endfunction

    // One cycle: drive at negedge, check gnt combinationally, then check the
    // loaded word one edge later against the scoreboard.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                        input logic [3:0] eg, input string name);
        exp_t e;
        @(negedge clk);
        bus.req       = r;
        bus.lock      = l;
        bus.out_ready = rdy;
        for (int i = 0; i < 4; i++) bus.in[i] = 16'($urandom);
        #1;
        chk({name, " gnt"}, 32'(bus.gnt), 32'(eg));
        if (eg != 4'b0) begin
            e.sel  = oh2idx(eg);
            e.data = bus.in[e.sel];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (eg != 4'b0) begin
            if (sb.size() == 0) begin
                chk({name, " scoreboard empty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
                chk({name, " out_sel"}, 32'(bus.out_sel), 32'(e.sel));
                chk({name, " out"}, 32'(bus.out), 32'(e.data));
            end
        end
    endtask

    logic [15:0] held_out;
    logic [1:0]  held_sel;

    initial begin
        // Reset default: full rotation from requester 0
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0001));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0010));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0100));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b1000));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0001));
        // Burst lock with ptr at 0: bursts of three to 1, then one to 2
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(mk(4'b0110, 4'b0010, 1'b1, 4'b0010));
            tbl.push_back(mk(4'b0110, 4'b0010, 1'b1, 4'b0010));
            tbl.push_back(mk(4'b0110, 4'b0010, 1'b1, 4'b0010));
            tbl.push_back(mk(4'b0110, 4'b0010, 1'b1, 4'b0100));
        end
        // Sparse/wrap: grant 3, wrap to 0, then 3 alone every cycle
        tbl.push_back(mk(4'b1000, 4'b0000, 1'b1, 4'b1000));
        tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 4'b0001));
        tbl.push_back(mk(4'b1000, 4'b0000, 1'b1, 4'b1000));
        tbl.push_back(mk(4'b1000, 4'b0000, 1'b1, 4'b1000));
        tbl.push_back(mk(4'b1000, 4'b0000, 1'b1, 4'b1000));

        bus.req = 4'b1111; bus.lock = '0; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) bus.in[i] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("gnt during rst", 32'(bus.gnt), 32'd0);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out", 32'(bus.out), 32'd0);
        chk("reset out_sel", 32'(bus.out_sel), 32'd0);
        rst = 1'b0;
        bus.req = '0;

        foreach (tbl[k])
            step(tbl[k].req, tbl[k].lock, tbl[k].rdy, tbl[k].gnt, $sformatf("vec%0d", k));

        // Idle drain
        held_out = bus.out;
        held_sel = bus.out_sel;
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, "drain");
        chk("drain out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain out hold", 32'(bus.out), 32'(held_out));
        chk("drain sel hold", 32'(bus.out_sel), 32'(held_sel));

        // Stall: load a word, then hold out_ready low for 5 cycles
        step(4'b0001, 4'b0000, 1'b1, 4'b0001, "stall load");
        held_out = bus.out;
        held_sel = bus.out_sel;
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b0000, 1'b0, 4'b0000, $sformatf("stall%0d", k));
            chk("stall out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall out", 32'(bus.out), 32'(held_out));
            chk("stall sel", 32'(bus.out_sel), 32'(held_sel));
        end
        step(4'b1111, 4'b0000, 1'b1, 4'b0010, "stall release");

        // Reset while a word is held under backpressure
        @(negedge clk);
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.out_ready = 1'b0;
        #1;
        chk("midrst gnt", 32'(bus.gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst out", 32'(bus.out), 32'd0);
        chk("midrst out_sel", 32'(bus.out_sel), 32'd0);
        rst = 1'b0;
        bus.req = '0;
        step(4'b0110, 4'b0000, 1'b1, 4'b0010, "post-rst lowest");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
